cam_pixel_stream: RTL and testbench
===================================

CAM_PIXEL_STREAM -- requirements
Module: cam_pixel_stream

Interface
REQ-001 Parameter CAMERA_COLS, default 640, Y pixels per line.
REQ-002 Parameter CAMERA_ROWS, default 480, lines per frame.
REQ-003 Parameter VSYNC_MIN, default 3*784*2 (three line times in pclk), minimum vsync-high cycles for a valid frame start.
REQ-004 pclk  in  1  camera pixel clock; all logic on rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  arm capture of frames; sampled only in IDLE.
REQ-007 vsync  in  1  camera frame sync, active-high.
REQ-008 href  in  1  camera line valid, active-high.
REQ-009 d  in  8  camera data byte, YUV422 order Y,U,Y,V.
REQ-010 pix_valid  out  1  one-cycle strobe: pix_y/pix_col/pix_row valid.
REQ-011 pix_y  out  8  luminance byte.
REQ-012 pix_col  out  10  column index 0..CAMERA_COLS-1.
REQ-013 pix_row  out  10  row index 0..CAMERA_ROWS-1.
REQ-014 frame_start  out  1  one-cycle strobe on first href of a valid frame.
REQ-015 frame_end  out  1  one-cycle strobe after last line of a good frame.
REQ-016 frame_err  out  1  one-cycle strobe when a frame is aborted.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, VSCOUNT, VSWAIT, ARMED, LINE, GAP.
REQ-019 IDLE -> VSCOUNT when enable & vsync; counter vs_cnt cleared in IDLE.
REQ-020 VSCOUNT: vs_cnt increments per cycle; vsync low before vs_cnt==VSYNC_MIN -> IDLE (no strobe); vs_cnt==VSYNC_MIN -> VSWAIT.
REQ-021 VSWAIT -> ARMED on vsync low; row counter cleared to 0.
REQ-022 ARMED -> LINE on href high; frame_start asserted that cycle's successor (registered, latency 1).
REQ-023 LINE: byte phase toggles each href-high cycle, phase 0 on first byte; phase-0 bytes are Y.
REQ-024 Y byte with col < CAMERA_COLS: next cycle pix_valid=1, pix_y=byte, pix_col=col, pix_row=row; col increments; latency exactly 1 cycle.
REQ-025 Y bytes with col >= CAMERA_COLS: discarded, no pix_valid, line marked overlong.
REQ-026 LINE -> GAP on href low; row increments; col and phase cleared.
REQ-027 Line with col != CAMERA_COLS at href fall (short or overlong): frame_err strobe, -> IDLE.
REQ-028 GAP: row==CAMERA_ROWS -> frame_end strobe, -> IDLE; else href high -> LINE.
REQ-029 vsync high in ARMED, LINE or GAP: frame_err strobe, -> VSCOUNT with vs_cnt=1 (resync, no IDLE pass).
REQ-030 enable deassert mid-frame does not abort; next frame not armed.
REQ-031 Counters saturate never; widths: vs_cnt 14 bits, col/row 10 bits; VSYNC_MIN < 2^14.
REQ-032 frame_end and frame_err mutually exclusive; at most one per frame.

Reset
REQ-033 Reset forces IDLE; pix_valid, frame_start, frame_end, frame_err, busy = 0; pix_y, pix_col, pix_row, vs_cnt, col, row, phase = 0.
REQ-034 Reset mid-line: no strobes on release; capture restarts only on a fresh qualified vsync.

Structure
REQ-035 CAMERA_COLS, CAMERA_ROWS, VSYNC_MIN and the state enum live in the shared camera defines package, also consumed by the decimation stage.
REQ-036 One sub-module, cam_vsync_qual, holds vs_cnt and the VSYNC_MIN comparison; rest flat.

Verification
REQ-037 Clean frame, COLS=8, ROWS=4, VSYNC_MIN=6: vsync 6 high, 16-byte lines -> 32 pix_valid, pix_y = bytes 0,2,4..., frame_start once, frame_end once after row 3.
REQ-038 Vsync glitch 3 cycles (VSYNC_MIN=6) -> stays IDLE, no strobes, busy low afterward.
REQ-039 Line 2 only 14 bytes (COLS=8) -> 7 pix_valid on row 2, frame_err at href fall, no frame_end.
REQ-040 Vsync rises during row 1 -> frame_err one cycle, next valid frame captured with pix_row restarting at 0.
REQ-041 Reset asserted mid-row 2 for 2 cycles -> all outputs 0; capture resumes only after next vsync >= VSYNC_MIN.
REQ-042 enable dropped during row 1 -> current frame ends with frame_end; following vsync ignored, busy 0.

Source files
------------

// File: rtl/cam_pixel_stream_pkg.sv
// cam_pixel_stream_pkg: shared camera geometry defaults, vsync qualification length and capture FSM states
package cam_pixel_stream_pkg;
   localparam int CAM_COLS      = 640;
   localparam int CAM_ROWS      = 480;
   localparam int CAM_VSYNC_MIN = 3 * 784 * 2;
   typedef enum logic [2:0] {IDLE, VSCOUNT, VSWAIT, ARMED, LINE, GAP} cam_state_t;
endpackage

// File: rtl/cam_vsync_qual.sv
// cam_vsync_qual: counts vsync-high cycles and flags when the minimum frame-sync length is reached
module cam_vsync_qual
   import cam_pixel_stream_pkg::*;
#(
   parameter int VSYNC_MIN = CAM_VSYNC_MIN
) (
   input  logic pclk,
   input  logic reset,
   input  logic load,
   input  logic clr,
   input  logic inc,
   output logic done
);
   logic [13:0] vs_cnt;
   // load counts the cycle that first sees vsync high, so vs_cnt equals high cycles seen
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) vs_cnt <= '0;
      else if (load) vs_cnt <= 14'd1;
      else if (clr) vs_cnt <= '0;
      else if (inc && !done) vs_cnt <= vs_cnt + 14'd1;
   end
   assign done = vs_cnt == 14'(VSYNC_MIN);
endmodule

// File: rtl/cam_pixel_stream.sv
// cam_pixel_stream: decodes camera vsync/href framing and emits Y pixels with column/row indices
module cam_pixel_stream
   import cam_pixel_stream_pkg::*;
#(
   parameter int CAMERA_COLS = CAM_COLS,
   parameter int CAMERA_ROWS = CAM_ROWS,
   parameter int VSYNC_MIN   = CAM_VSYNC_MIN
) (
   input  logic       pclk,
   input  logic       reset,
   input  logic       enable,
   input  logic       vsync,
   input  logic       href,
   input  logic [7:0] d,
   output logic       pix_valid,
   output logic [7:0] pix_y,
   output logic [9:0] pix_col,
   output logic [9:0] pix_row,
   output logic       frame_start,
   output logic       frame_end,
   output logic       frame_err,
   output logic       busy
);
   localparam logic [9:0] COLS = 10'(CAMERA_COLS);
   localparam logic [9:0] ROWS = 10'(CAMERA_ROWS);
   cam_state_t state, state_nx;
   logic [9:0] col, row;
   logic phase, overlong, vs_done, vs_load, in_frame, frame_done, byte_en, take_y, line_bad, line_ok;
   logic frame_start_nx, frame_end_nx, frame_err_nx;
   cam_vsync_qual #(.VSYNC_MIN(VSYNC_MIN)) u_vsync_qual (
      .pclk(pclk),
      .reset(reset),
      .load(vs_load),
      .clr(state == IDLE),
      .inc(state == VSCOUNT),
      .done(vs_done)
   );
   // the href cycle that leaves ARMED or GAP already carries byte 0 of the line
   always_comb begin
      in_frame = state == ARMED || state == LINE || state == GAP;
      frame_done = state == GAP && row == ROWS;
      byte_en = href && !vsync && in_frame && !frame_done;
      take_y = byte_en && !phase && col < COLS;
      line_bad = col != COLS || overlong;
      line_ok = state == LINE && !vsync && !href && !line_bad;
   end
   always_comb begin
      state_nx = state;
      vs_load = 1'b0;
      frame_start_nx = 1'b0;
      frame_end_nx = 1'b0;
      frame_err_nx = 1'b0;
      case (state)
         IDLE: begin
            state_nx = enable && vsync ? VSCOUNT : IDLE;
            vs_load = enable && vsync;
         end
         VSCOUNT: state_nx = vs_done ? VSWAIT : vsync ? VSCOUNT : IDLE;
         VSWAIT: state_nx = vsync ? VSWAIT : ARMED;
         ARMED: begin
            state_nx = href ? LINE : ARMED;
            frame_start_nx = href;
         end
         LINE: begin
            state_nx = href ? LINE : line_bad ? IDLE : GAP;
            frame_err_nx = !href && line_bad;
         end
         GAP: begin
            state_nx = frame_done ? IDLE : href ? LINE : GAP;
            frame_end_nx = frame_done;
         end
         default: state_nx = IDLE;
      endcase
      // a completed frame wins over a coincident vsync; otherwise vsync resyncs straight into counting
      if (vsync && in_frame && !frame_done) begin
         state_nx = VSCOUNT;
         vs_load = 1'b1;
         frame_start_nx = 1'b0;
         frame_err_nx = 1'b1;
      end
   end
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pix_valid <= 1'b0;
         pix_y <= '0;
         pix_col <= '0;
         pix_row <= '0;
         frame_start <= 1'b0;
         frame_end <= 1'b0;
         frame_err <= 1'b0;
         col <= '0;
         row <= '0;
         phase <= 1'b0;
         overlong <= 1'b0;
      end else begin
         state <= state_nx;
         frame_start <= frame_start_nx;
         frame_end <= frame_end_nx;
         frame_err <= frame_err_nx;
         pix_valid <= take_y;
         if (take_y) begin
            pix_y <= d;
            pix_col <= col;
            pix_row <= row;
         end
         col <= byte_en ? col + 10'(take_y) : '0;
         phase <= byte_en && !phase;
         overlong <= byte_en && (overlong || (!phase && col >= COLS));
         row <= !in_frame ? '0 : line_ok ? row + 10'd1 : row;
      end
   end
   assign busy = state != IDLE;
endmodule

// File: tb/tb_cam_pixel_stream.sv
// tb_cam_pixel_stream: directed frames on a small 8x4 sensor with hand-computed expected pixels and strobe counts
module tb_cam_pixel_stream;
   localparam int COLS = 8;
   localparam int ROWS = 4;
   localparam int VMIN = 6;
   logic pclk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic vsync = 1'b0;
   logic href = 1'b0;
   logic [7:0] d = '0;
   logic pix_valid, frame_start, frame_end, frame_err, busy;
   logic [7:0] pix_y;
   logic [9:0] pix_col, pix_row;
   int n_assert = 0;
   int n_fail = 0;
   int n_pix = 0;
   int n_fs = 0;
   int n_fe = 0;
   int n_ferr = 0;
   always #5 pclk = ~pclk;
   cam_pixel_stream #(.CAMERA_COLS(COLS), .CAMERA_ROWS(ROWS), .VSYNC_MIN(VMIN)) dut (
      .pclk(pclk),
      .reset(reset),
      .enable(enable),
      .vsync(vsync),
      .href(href),
      .d(d),
      .pix_valid(pix_valid),
      .pix_y(pix_y),
      .pix_col(pix_col),
      .pix_row(pix_row),
      .frame_start(frame_start),
      .frame_end(frame_end),
      .frame_err(frame_err),
      .busy(busy)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   // one clock: apply inputs, then check the registered outputs just after the edge
   task automatic tick(input logic v, input logic h, input logic [7:0] dat, input logic ev,
                       input logic [7:0] ey, input logic [9:0] ec, input logic [9:0] er);
      vsync = v;
      href = h;
      d = dat;
      @(posedge pclk);
      #1;
      chk("pix_valid", {31'd0, pix_valid}, {31'd0, ev});
      if (ev) begin
         chk("pix_y", {24'd0, pix_y}, {24'd0, ey});
         chk("pix_col", {22'd0, pix_col}, {22'd0, ec});
         chk("pix_row", {22'd0, pix_row}, {22'd0, er});
      end
      chk("end_err_exclusive", {31'd0, frame_end & frame_err}, 32'd0);
      n_pix += int'(pix_valid);
      n_fs += int'(frame_start);
      n_fe += int'(frame_end);
      n_ferr += int'(frame_err);
   endtask
   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 10'd0, 10'd0);
   endtask
   task automatic vpulse(input int n);
      repeat (n) tick(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 10'd0, 10'd0);
      idle(3);
   endtask
   // byte i of row r is r*16+i; even bytes are Y and appear at col i/2 when captured
   task automatic line(input int r, input int nb, input logic cap, input int gap);
      for (int i = 0; i < nb; i++) begin
         logic [7:0] b;
         b = 8'(r * 16 + i);
         tick(1'b0, 1'b1, b, cap && (i % 2 == 0) && (i / 2 < COLS), b, 10'(i / 2), 10'(r));
      end
      idle(gap);
   endtask
   task automatic frame(input logic cap);
      for (int r = 0; r < ROWS; r++) line(r, 2 * COLS, cap, 3);
   endtask
   task automatic clr_counts();
      n_pix = 0;
      n_fs = 0;
      n_fe = 0;
      n_ferr = 0;
   endtask
   task automatic chk_counts(input string tag, input int pix, input int fs, input int fe, input int ferr);
      chk({tag, "_pix"}, n_pix, pix);
      chk({tag, "_frame_start"}, n_fs, fs);
      chk({tag, "_frame_end"}, n_fe, fe);
      chk({tag, "_frame_err"}, n_ferr, ferr);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
      chk({tag, "_pix_y"}, {24'd0, pix_y}, 32'd0);
      chk({tag, "_pix_col"}, {22'd0, pix_col}, 32'd0);
      chk({tag, "_pix_row"}, {22'd0, pix_row}, 32'd0);
      chk({tag, "_strobes"}, {29'd0, frame_start, frame_end, frame_err}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask
   initial begin
      idle(2);
      chk_zero("reset");
      reset = 1'b0;
      enable = 1'b1;
      idle(2);
      // clean frame
      clr_counts();
      vpulse(VMIN);
      frame(1'b1);
      chk_counts("clean", 32, 1, 1, 0);
      // short vsync glitch is not a frame start
      clr_counts();
      vpulse(3);
      chk("glitch_busy", {31'd0, busy}, 32'd0);
      line(0, 16, 1'b0, 3);
      chk_counts("glitch", 0, 0, 0, 0);
      // row 2 short by one Y byte
      clr_counts();
      vpulse(VMIN);
      line(0, 16, 1'b1, 3);
      line(1, 16, 1'b1, 3);
      line(2, 14, 1'b1, 3);
      line(3, 16, 1'b0, 3);
      chk_counts("short", 23, 1, 0, 1);
      // overlong row 0: ninth Y byte is dropped
      clr_counts();
      vpulse(VMIN);
      line(0, 18, 1'b1, 3);
      line(1, 16, 1'b0, 3);
      chk_counts("overlong", 8, 1, 0, 1);
      // vsync during row 1 resyncs into a fresh frame
      clr_counts();
      vpulse(VMIN);
      line(0, 16, 1'b1, 3);
      line(1, 6, 1'b1, 0);
      vpulse(VMIN);
      chk("resync_err", n_ferr, 1);
      frame(1'b1);
      chk_counts("resync", 43, 2, 1, 1);
      // reset in the middle of row 2
      clr_counts();
      vpulse(VMIN);
      line(0, 16, 1'b1, 3);
      line(1, 16, 1'b1, 3);
      line(2, 6, 1'b1, 0);
      reset = 1'b1;
      tick(1'b0, 1'b1, 8'd38, 1'b0, 8'd0, 10'd0, 10'd0);
      tick(1'b0, 1'b1, 8'd39, 1'b0, 8'd0, 10'd0, 10'd0);
      chk_zero("midreset");
      reset = 1'b0;
      line(2, 10, 1'b0, 3);
      line(3, 16, 1'b0, 3);
      vpulse(VMIN - 1);
      line(0, 16, 1'b0, 3);
      chk_counts("postreset", 19, 1, 0, 0);
      vpulse(VMIN);
      frame(1'b1);
      chk_counts("recovered", 51, 2, 1, 0);
      // enable dropped mid-frame finishes that frame but arms no more
      clr_counts();
      vpulse(VMIN);
      line(0, 16, 1'b1, 3);
      enable = 1'b0;
      for (int r = 1; r < ROWS; r++) line(r, 16, 1'b1, 3);
      chk("disarm_end", n_fe, 1);
      vpulse(VMIN);
      chk("disarm_busy", {31'd0, busy}, 32'd0);
      line(0, 16, 1'b0, 3);
      chk_counts("disarm", 32, 1, 1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
